fft_frame_scheduler: RTL and testbench

Shares the single serial radix-2 SDF FFT pipeline between NUM_SRC sample sources. Round-robin arbitration is done per frame. The granted source's 2^N real samples are streamed into the FFT, and a start pulse is generated with the first sample. Each frame's source ID is held in a tag FIFO, so the shuffled FFT output stream can be labelled with its originating source when the pipeline signals op_ready.

---
 rtl/fft_frame_scheduler.sv | 156 +++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: round-robin, per-frame sharing of one serial SDF FFT
// pipeline; a tag FIFO labels each shuffled output frame with its source.
module fft_frame_scheduler #(
  parameter int N         = 3,
  parameter int NUM_SRC   = 4,
  parameter int W         = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         src_req,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*W-1:0]       src_data,
  output logic [NUM_SRC-1:0]         src_gnt,
  output logic                       fft_start,
  output logic [W-1:0]               fft_ip,
  input  logic                       fft_op_ready,
  output logic                       out_valid,
  output logic                       out_first,
  output logic [$clog2(NUM_SRC)-1:0] out_tag,
  output logic                       busy,
  output logic                       err_underrun,
  output logic                       err_orphan
);

  localparam int TW = $clog2(NUM_SRC);
  localparam int AW = $clog2(TAG_DEPTH);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t         state;
  logic [N-1:0]   cnt;
  logic [N-1:0]   ocnt;
  logic [TW-1:0]  gnt_id;
  logic [TW-1:0]  ptr;
  logic [TW-1:0]  tag_q;
  logic [TW-1:0]  tags [TAG_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  logic           empty;
  logic           full;
  logic           push;
  logic           pop;
  logic           last;
  logic [TW-1:0]  gnt_nxt;
  logic [W-1:0]   gnt_data;
  logic           gnt_valid;

  logic [TW-1:0]      arb_base;
  logic [TW-1:0]      arb_id;
  logic [NUM_SRC-1:0] arb_req;
  logic               arb_hit;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign last  = cnt == '1;
  assign push  = (state == LOAD) && (cnt == '0);
  assign pop   = fft_op_ready && !empty;

  assign gnt_nxt   = (int'(gnt_id) == NUM_SRC - 1) ?
                     '0 : gnt_id + 1'b1;
  assign gnt_data  = src_data[int'(gnt_id)*W +: W];
  assign gnt_valid = src_valid[gnt_id];

  // At a frame end the finishing grantee is masked so a contiguous
  // grant always moves on to another requester.
  always_comb begin
    arb_base = (state == LOAD) ? gnt_nxt : ptr;
    arb_req  = (state == LOAD) ? (src_req & ~src_gnt) : src_req;
    arb_hit  = 1'b0;
    arb_id   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!arb_hit &&
          arb_req[(int'(arb_base) + i) % NUM_SRC]) begin
        arb_hit = 1'b1;
        arb_id  = TW'((int'(arb_base) + i) % NUM_SRC);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      src_gnt      <= '0;
      gnt_id       <= '0;
      ptr          <= '0;
      cnt          <= '0;
      fft_start    <= 1'b0;
      fft_ip       <= '0;
      err_underrun <= 1'b0;
    end else begin
      fft_start <= 1'b0;
      fft_ip    <= '0;
      unique case (state)
        IDLE: begin
          if (arb_hit && !full) begin
            state   <= LOAD;
            src_gnt <= NUM_SRC'(1) << arb_id;
            gnt_id  <= arb_id;
            cnt     <= '0;
          end
        end
        LOAD: begin
          fft_start <= cnt == '0;
          if (gnt_valid) fft_ip <= gnt_data;
          else err_underrun <= 1'b1;
          cnt <= cnt + 1'b1;
          if (last) begin
            ptr <= gnt_nxt;
            if (arb_hit && !full) begin
              src_gnt <= NUM_SRC'(1) << arb_id;
              gnt_id  <= arb_id;
            end else begin
              state   <= IDLE;
              src_gnt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) tags[wr_ptr[AW-1:0]] <= gnt_id;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ocnt       <= '0;
      tag_q      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        tag_q  <= tags[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
        ocnt   <= '1;
      end else if (ocnt != '0) begin
        ocnt <= ocnt - 1'b1;
      end
      if (fft_op_ready && empty) err_orphan <= 1'b1;
    end
  end

  // Output framing starts in the op_ready cycle itself.
  assign out_valid = pop || (ocnt != '0);
  assign out_first = pop;
  assign out_tag   = pop ? tags[rd_ptr[AW-1:0]] : tag_q;
  assign busy      = (state != IDLE) || !empty;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb_fft_frame_scheduler: directed scenarios plus randomized traffic
// against a frame-level reference model.
module tb_fft_frame_scheduler;

  localparam int N  = 3;
  localparam int NS = 4;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int L  = 1 << N;
  localparam int TW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NS-1:0]   src_req;
  logic [NS-1:0]   src_valid;
  logic [NS*W-1:0] src_data;
  logic [NS-1:0]   src_gnt;
  logic            fft_start;
  logic [W-1:0]    fft_ip;
  logic            fft_op_ready;
  logic            out_valid;
  logic            out_first;
  logic [TW-1:0]   out_tag;
  logic            busy;
  logic            err_underrun;
  logic            err_orphan;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_frame_scheduler #(
    .N(N), .NUM_SRC(NS), .W(W), .TAG_DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .src_req(src_req),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_gnt(src_gnt),
    .fft_start(fft_start),
    .fft_ip(fft_ip),
    .fft_op_ready(fft_op_ready),
    .out_valid(out_valid),
    .out_first(out_first),
    .out_tag(out_tag),
    .busy(busy),
    .err_underrun(err_underrun),
    .err_orphan(err_orphan)
  );

  // Reference model: frames, a tag queue and countdowns.
  bit           m_load;
  int           m_cnt;
  int           m_src;
  int           m_ptr;
  int           m_ocnt;
  int           m_tag;
  bit           m_start;
  bit           m_eu;
  bit           m_eo;
  logic [W-1:0] m_ip;
  int           tagq[$];
  int           m_pre;
  int           m_pick;

  function automatic int rr_pick(logic [NS-1:0] req,
                                 int from, int excl);
    for (int i = 0; i < NS; i++) begin
      automatic int s = (from + i) % NS;
      if (req[s] && s != excl) return s;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_load = 0; m_cnt = 0; m_src = 0; m_ptr = 0;
      m_ocnt = 0; m_tag = 0; m_start = 0;
      m_eu = 0; m_eo = 0; m_ip = '0;
      tagq.delete();
    end else begin
      m_pre = tagq.size();
      if (fft_op_ready && m_pre > 0) begin
        m_tag  = tagq.pop_front();
        m_ocnt = L - 1;
      end else if (m_ocnt > 0) begin
        m_ocnt--;
      end
      if (fft_op_ready && m_pre == 0) m_eo = 1;
      m_start = 0;
      m_ip = '0;
      if (m_load) begin
        m_start = (m_cnt == 0);
        if (src_valid[m_src]) m_ip = src_data[m_src*W +: W];
        else m_eu = 1;
        if (m_cnt == 0) tagq.push_back(m_src);
        if (m_cnt == L - 1) begin
          m_ptr  = (m_src + 1) % NS;
          m_pick = (m_pre < D) ? rr_pick(src_req, m_ptr, m_src) : -1;
          if (m_pick >= 0) begin
            m_src = m_pick;
            m_cnt = 0;
          end else begin
            m_load = 0;
          end
        end else begin
          m_cnt++;
        end
      end else begin
        m_pick = (m_pre < D) ? rr_pick(src_req, m_ptr, -1) : -1;
        if (m_pick >= 0) begin
          m_load = 1;
          m_src  = m_pick;
          m_cnt  = 0;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    src_req = '0;
    src_valid = '0;
    src_data = '0;
    fft_op_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    src_req = '1;
    src_valid = '1;
    fft_op_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (src_gnt !== '0) begin
      n_bad++;
      $display("FAIL reset_gnt got=%b exp=0", src_gnt);
    end
    n_cmp++;
    if ({fft_start, fft_ip} !== '0) begin
      n_bad++;
      $display("FAIL reset_ip got st=%b ip=%h exp 0",
               fft_start, fft_ip);
    end
    n_cmp++;
    if ({out_valid, out_first, out_tag} !== '0) begin
      n_bad++;
      $display("FAIL reset_out got v=%b f=%b t=%0d exp 0",
               out_valid, out_first, out_tag);
    end
    n_cmp++;
    if ({busy, err_underrun, err_orphan} !== '0) begin
      n_bad++;
      $display("FAIL reset_stat got b=%b u=%b o=%b exp 0",
               busy, err_underrun, err_orphan);
    end
    fft_op_ready = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [NS-1:0] eg;
    logic [W-1:0]  ei;
    do_reset();
    src_valid = '1;
    src_req = 4'b0010;
    src_data[W +: W] = 16'd1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      src_req = '0;
      src_data[W +: W] = (k <= 8) ? W'(k) : 16'hdead;
      fft_op_ready = (k == 12);
      #1;
      eg = (k <= 8) ? 4'b0010 : 4'b0000;
      ei = (k >= 2 && k <= 9) ? W'(k - 1) : '0;
      n_cmp++;
      if (src_gnt !== eg) begin
        n_bad++;
        $display("FAIL single_gnt k=%0d got=%b exp=%b", k, src_gnt, eg);
      end
      n_cmp++;
      if ({fft_start, fft_ip} !== {(k == 2), ei}) begin
        n_bad++;
        $display("FAIL single_ip k=%0d got st=%b ip=%0d exp st=%b ip=%0d",
                 k, fft_start, fft_ip, (k == 2), ei);
      end
      if (k >= 12) begin
        n_cmp++;
        if ({out_valid, out_first} !== {(k <= 19), (k == 12)}) begin
          n_bad++;
          $display("FAIL single_out k=%0d got v=%b f=%b exp v=%b f=%b",
                   k, out_valid, out_first, (k <= 19), (k == 12));
        end
      end
      if (k >= 12 && k <= 19) begin
        n_cmp++;
        if (out_tag !== 2'd1) begin
          n_bad++;
          $display("FAIL single_tag k=%0d got=%0d exp=1", k, out_tag);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NS-1:0] eg;
    logic [TW-1:0] et;
    bit            pulse;
    do_reset();
    src_valid = '1;
    src_req = '1;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      src_req = (k < 40) ? '1 : '0;
      for (int i = 0; i < NS; i++) src_data[i*W +: W] = W'($urandom);
      pulse = (k == 12) || (k == 20) || (k == 28) || (k == 36);
      fft_op_ready = pulse;
      #1;
      eg = (k <= 40) ? NS'(1) << (((k - 1) / L) % NS) : '0;
      n_cmp++;
      if (src_gnt !== eg) begin
        n_bad++;
        $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, src_gnt, eg);
      end
      n_cmp++;
      if (out_valid !== (k >= 12 && k <= 43)) begin
        n_bad++;
        $display("FAIL rr_valid k=%0d got=%b", k, out_valid);
      end
      if (pulse) begin
        et = TW'((k - 12) / L);
        n_cmp++;
        if ({out_first, out_tag} !== {1'b1, et}) begin
          n_bad++;
          $display("FAIL rr_tag k=%0d got f=%b t=%0d exp f=1 t=%0d",
                   k, out_first, out_tag, et);
        end
      end
    end
    fft_op_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [NS-1:0] prev;
    logic [NS-1:0] first_new;
    int            frames;
    do_reset();
    src_valid = '1;
    src_req = '1;
    prev = '0;
    frames = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      #1;
      if (src_gnt != '0 && src_gnt != prev) frames++;
      prev = src_gnt;
    end
    n_cmp++;
    if (frames !== 4) begin
      n_bad++;
      $display("FAIL bp_frames got=%0d exp=4", frames);
    end
    n_cmp++;
    if ({src_gnt, busy} !== {4'b0000, 1'b1}) begin
      n_bad++;
      $display("FAIL bp_idle got gnt=%b busy=%b exp gnt=0 busy=1",
               src_gnt, busy);
    end
    @(negedge clk);
    fft_op_ready = 1'b1;
    #1;
    n_cmp++;
    if ({out_first, out_tag} !== {1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL bp_pop got f=%b t=%0d exp f=1 t=0",
               out_first, out_tag);
    end
    frames = 0;
    first_new = '0;
    prev = '0;
    for (int k = 52; k <= 80; k++) begin
      @(negedge clk);
      fft_op_ready = 1'b0;
      #1;
      if (src_gnt != '0 && src_gnt != prev) begin
        frames++;
        if (first_new == '0) first_new = src_gnt;
      end
      prev = src_gnt;
    end
    n_cmp++;
    if ({frames, first_new} !== {32'd1, 4'b0001}) begin
      n_bad++;
      $display("FAIL bp_regrant got frames=%0d gnt=%b exp 1 0001",
               frames, first_new);
    end
  endtask

  task automatic test_underrun();
    logic [W-1:0] ei;
    do_reset();
    src_valid = '1;
    src_req = 4'b0100;
    src_data[2*W +: W] = 16'd1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      src_req = '0;
      src_data[2*W +: W] = W'(k);
      src_valid[2] = (k != 4);
      #1;
      ei = (k >= 2 && k <= 9 && k != 5) ? W'(k - 1) : '0;
      n_cmp++;
      if (src_gnt !== ((k <= 8) ? 4'b0100 : 4'b0000)) begin
        n_bad++;
        $display("FAIL ur_gnt k=%0d got=%b", k, src_gnt);
      end
      n_cmp++;
      if (fft_ip !== ei) begin
        n_bad++;
        $display("FAIL ur_ip k=%0d got=%0d exp=%0d", k, fft_ip, ei);
      end
      n_cmp++;
      if (err_underrun !== (k >= 5)) begin
        n_bad++;
        $display("FAIL ur_err k=%0d got=%b exp=%b",
                 k, err_underrun, (k >= 5));
      end
    end
  endtask

  task automatic test_orphan();
    do_reset();
    @(negedge clk);
    fft_op_ready = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, out_first, err_orphan} !== 3'b000) begin
      n_bad++;
      $display("FAIL orph_pulse got v=%b f=%b o=%b exp 000",
               out_valid, out_first, err_orphan);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      fft_op_ready = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, busy, err_orphan} !== 3'b001) begin
        n_bad++;
        $display("FAIL orph_after k=%0d got v=%b b=%b o=%b exp 001",
                 k, out_valid, busy, err_orphan);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_valid = '1;
    for (int i = 0; i < NS; i++) src_data[i*W +: W] = W'(16'h1230 + i);
    src_req = 4'b0010;
    repeat (8) begin
      @(negedge clk);
      src_req = '0;
    end
    @(negedge clk);
    src_req = '1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (src_gnt !== 4'b0100) begin
      n_bad++;
      $display("FAIL rm_gnt2 got=%b exp=0100", src_gnt);
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({src_gnt, fft_start, fft_ip} !== '0) begin
      n_bad++;
      $display("FAIL rm_load got gnt=%b st=%b ip=%h exp 0",
               src_gnt, fft_start, fft_ip);
    end
    n_cmp++;
    if ({out_valid, out_tag, busy, err_underrun} !== '0) begin
      n_bad++;
      $display("FAIL rm_stat got v=%b t=%0d b=%b u=%b exp 0",
               out_valid, out_tag, busy, err_underrun);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (src_gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL rm_first got=%b exp=0001", src_gnt);
    end
  endtask

  task automatic test_random(int cycles);
    logic [NS-1:0] eg;
    logic          ep;
    logic          ev;
    logic [TW-1:0] et;
    logic          eb;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      src_req = NS'($urandom_range(0, 15));
      src_valid = ($urandom_range(0, 19) == 0) ?
                  NS'($urandom) : '1;
      for (int i = 0; i < NS; i++) src_data[i*W +: W] = W'($urandom);
      fft_op_ready = ($urandom_range(0, 9) == 0);
      #1;
      eg = m_load ? NS'(1) << m_src : '0;
      ep = fft_op_ready && (tagq.size() > 0);
      ev = ep || (m_ocnt > 0);
      et = ep ? TW'(tagq[0]) : TW'(m_tag);
      eb = m_load || (tagq.size() > 0);
      n_cmp++;
      if ({src_gnt, fft_start, fft_ip} !== {eg, m_start, m_ip}) begin
        n_bad++;
        $display("FAIL rnd_load c=%0d got %b %b %h exp %b %b %h",
                 c, src_gnt, fft_start, fft_ip, eg, m_start, m_ip);
      end
      n_cmp++;
      if ({out_valid, out_first} !== {ev, ep} ||
          (ev && out_tag !== et)) begin
        n_bad++;
        $display("FAIL rnd_out c=%0d got v=%b f=%b t=%0d exp %b %b %0d",
                 c, out_valid, out_first, out_tag, ev, ep, et);
      end
      n_cmp++;
      if ({busy, err_underrun, err_orphan} !== {eb, m_eu, m_eo}) begin
        n_bad++;
        $display("FAIL rnd_stat c=%0d got %b%b%b exp %b%b%b",
                 c, busy, err_underrun, err_orphan, eb, m_eu, m_eo);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_underrun();
    test_orphan();
    test_reset_mid();
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
